inperiph_debounce: RTL and testbench
====================================

Name: inperiph_debounce

Overview:
- Memory-mapped input-peripheral responder for the 0x9xx load/store region.
- Answers processor loads and stores for switches and push-buttons.
- Synchronises and debounces the raw board inputs, then keeps sticky press flags and per-button press counters.
- The load/store unit drives addr/sdata/wren and samples rdata combinationally in the same cycle.

Parameters:
- NSW, 18: number of switch inputs in use. sw_raw bits at or above NSW are ignored and read as 0.
- NBTN, 4: number of buttons in use (maximum 4).
- BTN_ACTIVE_LOW, 1: when 1, btn_raw is inverted before synchronisation, so a pressed button reads as 1.
- DB_DIV, 50000: debounce sample period in clocks. Minimum 1, where a tick occurs every cycle.

Ports:
- clk  in  1: system clock.
- rst  in  1: synchronous active-high reset.
- addr  in  8: word offset within the input region, addr[7:0].
- sdata  in  32: store data.
- wren  in  1: store strobe, already qualified for this region.
- sw_raw  in  32: asynchronous switch inputs.
- btn_raw  in  32: asynchronous button inputs.
- rdata  out  32: read data, combinational from registered state.
- btn_irq  out  1: OR of all sticky press bits, registered.

Behaviour:
- Register map (addr[7:0]); all other offsets read 0 and ignore writes:
  - 0x00 SW: debounced switches, zero-extended. Read-only.
  - 0x10 BTN: debounced button levels after polarity correction. Read-only.
  - 0x14 PRESS: sticky rising-edge flags, bits [NBTN-1:0]. Write-1-to-clear using sdata.
  - 0x18 PCNT: byte i is an 8-bit press counter for button i; counters wrap 255 -> 0. Any write clears all counters.
- Read path:
  - Zero-latency: rdata = mux(addr, registers) within the same cycle.
  - A write's effect is visible on rdata in the cycle after the write edge.
- Synchroniser: two flops per bit (sync1 <= raw, sync2 <= sync1).
- Tick generator:
  - Counter 0..DB_DIV-1; tick is asserted when the counter equals DB_DIV-1, then the counter wraps to 0.
  - With DB_DIV=1, tick is constant 1.
- Debounce, per bit, on tick only:
  - s0 <= sync2; s1 <= s0.
  - deb <= sync2 when sync2 == s0 == s1 (pre-edge values); otherwise deb holds.
  - Input changes shorter than 3 consecutive ticks are rejected.
- Latency (DB_DIV=1): a raw change before edge N appears in SW/BTN after edge N+4, i.e. 5 edges in total.
- Edge detect:
  - deb_prev <= deb_btn every cycle.
  - A press is deb_btn & ~deb_prev; its effects land one edge after the BTN update.
  - On a press: the PRESS bit is set and counter i increments.
- PRESS update rule, per bit: next = (cur & ~(clr_mask)) | press.
  - clr_mask = sdata when wren is asserted and addr = 0x14, else 0.
  - Press beats clear in the same cycle, so no event is lost.
- PCNT clear coinciding with a press of button i: counter i becomes 1 and all other counters become 0.
- btn_irq is registered from the next-state PRESS value, so it follows PRESS with no extra lag.
- Stores always write all 32 bits of sdata as presented; byte and halfword merging is the load/store unit's responsibility.
- Reset (synchronous, rst=1 at an edge) returns every flop to 0:
  - Sync flops, samples, deb and deb_prev all go to 0; with BTN_ACTIVE_LOW=1, 0 is the post-inversion released level.
  - Tick counter, PRESS, PCNT and btn_irq go to 0.
  - rdata therefore reads 0 at every offset in the cycle after reset.
- Reset mid-debounce discards partial samples. A button held through reset registers as a fresh press once it is debounced after reset.

Test Plan:
1. DB_DIV=1, BTN_ACTIVE_LOW=0: set sw_raw=0x2A5 before edge N, hold, read addr 0x00 -> 0x0 through edge N+3, then 0x000002A5 after edge N+4.
2. DB_DIV=1: pulse btn_raw[0] high for 2 cycles -> BTN, PRESS and PCNT stay 0 and btn_irq stays 0.
3. DB_DIV=1: press btn 2 and hold 10 cycles, then release; repeat 3 times.
   - Read 0x14 -> 0x4 and 0x18 -> 0x00030000; btn_irq=1.
   - Write 0x14 with 0x4 -> next read is 0x0 and btn_irq=0.
4. Clear/press collision: arrange for a btn 1 press edge in the same cycle as a write of 0x2 to 0x14 and a write to 0x18.
   - Result: PRESS=0x2 and PCNT byte1=1.
5. Counter wrap: 256 debounced presses of btn 0 -> PCNT byte0=0x00, with no carry into byte1.
6. Reset: with DB_DIV=4, assert rst mid-sequence -> all offsets read 0 on the next cycle, and the tick counter restarts so the first tick occurs at the 4th edge after rst deasserts.

Source files
------------

// File: rtl/inperiph_debounce_if.sv
// rtl/inperiph_debounce_if.sv - load/store bus into the 0x9xx input-peripheral region
interface inperiph_debounce_if;
    logic [7:0]  addr;
    logic [31:0] sdata;
    logic        wren;
    logic [31:0] rdata;

    modport master (output addr, output sdata, output wren, input rdata);
    modport slave  (input addr, input sdata, input wren, output rdata);
endinterface

// File: rtl/inperiph_debounce.sv
// rtl/inperiph_debounce.sv - switch/button responder: sync, debounce, sticky press flags, press counters
module inperiph_debounce #(
    parameter int NSW            = 18,
    parameter int NBTN           = 4,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int DB_DIV         = 50000
) (
    input  logic                clk,
    input  logic                rst,
    inperiph_debounce_if.slave  bus,
    input  logic [31:0]         sw_raw,
    input  logic [31:0]         btn_raw,
    output logic                btn_irq
);
    localparam int NIN = NSW + NBTN;

    logic [NBTN-1:0] btn_pol;
    logic [NIN-1:0]  raw_in;
    logic [NIN-1:0]  sync1, sync2, s0, s1, deb, stable;
    logic [NSW-1:0]  deb_sw;
    logic [NBTN-1:0] deb_btn, deb_prev, press, press_q, press_next, clr_mask;
    logic [7:0]      pcnt [NBTN];
    logic            tick;
    logic            wr_press, wr_pcnt;
    logic [31:0]     sw_word, btn_word, press_word, pcnt_word;
    logic            unused_bits;

    assign btn_pol = (BTN_ACTIVE_LOW != 0) ? ~btn_raw[NBTN-1:0] : btn_raw[NBTN-1:0];
    assign raw_in  = {btn_pol, sw_raw[NSW-1:0]};
    assign unused_bits = ^{sw_raw, btn_raw, bus.sdata};

    generate
        if (DB_DIV <= 1) begin : g_tick_every
            assign tick = 1'b1;
        end else begin : g_tick_div
            localparam int CW = $clog2(DB_DIV);
            logic [CW-1:0] cnt;
            assign tick = (cnt == CW'(DB_DIV - 1));
            always_ff @(posedge clk) begin
                if (rst || tick) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

    // a bit only moves when the synchronised level and both earlier tick samples agree
    assign stable = ~(sync2 ^ s0) & ~(s0 ^ s1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            s0    <= '0;
            s1    <= '0;
            deb   <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            if (tick) begin
                s0  <= sync2;
                s1  <= s0;
                deb <= (stable & sync2) | (~stable & deb);
            end
        end
    end

    assign deb_sw   = deb[NSW-1:0];
    assign deb_btn  = deb[NIN-1:NSW];
    assign press    = deb_btn & ~deb_prev;
    assign wr_press = bus.wren && (bus.addr == 8'h14);
    assign wr_pcnt  = bus.wren && (bus.addr == 8'h18);
    assign clr_mask = wr_press ? bus.sdata[NBTN-1:0] : '0;
    // a press in the same cycle as its clear wins, so no event is dropped
    assign press_next = (press_q & ~clr_mask) | press;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_prev <= '0;
            press_q  <= '0;
            btn_irq  <= 1'b0;
            for (int i = 0; i < NBTN; i++) begin
                pcnt[i] <= 8'h00;
            end
        end else begin
            deb_prev <= deb_btn;
            press_q  <= press_next;
            btn_irq  <= |press_next;
            for (int i = 0; i < NBTN; i++) begin
                if (wr_pcnt) begin
                    pcnt[i] <= {7'b0, press[i]};
                end else begin
                    pcnt[i] <= pcnt[i] + {7'b0, press[i]};
                end
            end
        end
    end

    always_comb begin
        sw_word                 = '0;
        btn_word                = '0;
        press_word              = '0;
        pcnt_word               = '0;
        sw_word[NSW-1:0]        = deb_sw;
        btn_word[NBTN-1:0]      = deb_btn;
        press_word[NBTN-1:0]    = press_q;
        for (int i = 0; i < NBTN; i++) begin
            pcnt_word[8*i +: 8] = pcnt[i];
        end
    end

    always_comb begin
        bus.rdata = 32'h0;
        case (bus.addr)
            8'h00:   bus.rdata = sw_word;
            8'h10:   bus.rdata = btn_word;
            8'h14:   bus.rdata = press_word;
            8'h18:   bus.rdata = pcnt_word;
            default: bus.rdata = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_inperiph_debounce.sv
// tb/tb_inperiph_debounce.sv - bench for inperiph_debounce: reference model plus directed vectors
module tb_inperiph_debounce;
    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [7:0]  addr;
    logic [31:0] sdata, sw_raw, btn_raw;
    logic        wren;
    logic        irq_a, irq_b;
    int          vectors = 0;
    int          fails   = 0;
    bit          started = 1'b0;

    always #10 clk = ~clk;

    inperiph_debounce_if ba ();
    inperiph_debounce_if bb ();
    assign ba.addr  = addr;
    assign ba.sdata = sdata;
    assign ba.wren  = wren;
    assign bb.addr  = addr;
    assign bb.sdata = sdata;
    assign bb.wren  = wren;

    inperiph_debounce #(.NSW(18), .NBTN(4), .BTN_ACTIVE_LOW(0), .DB_DIV(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ba), .sw_raw(sw_raw), .btn_raw(btn_raw), .btn_irq(irq_a));
    inperiph_debounce #(.NSW(18), .NBTN(4), .BTN_ACTIVE_LOW(1), .DB_DIV(4)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bb), .sw_raw(sw_raw), .btn_raw(btn_raw), .btn_irq(irq_b));

    // model: per DUT, raw history, tick-sample history, debounced levels, flags and counters
    int          ddiv [2] = '{1, 4};
    bit          dinv [2] = '{1'b0, 1'b1};
    logic [21:0] rawh [2][$];
    logic [21:0] ts   [2][$];
    int          tcnt [2];
    logic [21:0] mdeb [2];
    logic [3:0]  mdebp [2];
    logic [3:0]  mpress [2];
    int          mcnt [2][4];

    task automatic model_step(input int d, input logic r);
        logic [21:0] cur, sample, nd;
        logic [3:0]  press, clr;
        bit          tick;
        cur = {dinv[d] ? ~btn_raw[3:0] : btn_raw[3:0], sw_raw[17:0]};
        if (r) begin
            rawh[d].delete();
            ts[d].delete();
            ts[d].push_back('0);
            ts[d].push_back('0);
            tcnt[d]   = 0;
            mdeb[d]   = '0;
            mdebp[d]  = '0;
            mpress[d] = '0;
            for (int k = 0; k < 4; k++) mcnt[d][k] = 0;
        end else begin
            sample = (rawh[d].size() >= 2) ? rawh[d][rawh[d].size()-2] : '0;
            tick = ((tcnt[d] % ddiv[d]) == ddiv[d] - 1);
            tcnt[d]++;
            nd = mdeb[d];
            if (tick) begin
                ts[d].push_back(sample);
                if (ts[d].size() > 3) void'(ts[d].pop_front());
                for (int i = 0; i < 22; i++)
                    if (ts[d][0][i] == ts[d][1][i] && ts[d][1][i] == ts[d][2][i])
                        nd[i] = ts[d][2][i];
            end
            press = mdeb[d][21:18] & ~mdebp[d];
            clr = (wren && addr == 8'h14) ? sdata[3:0] : 4'h0;
            mpress[d] = (mpress[d] & ~clr) | press;
            for (int k = 0; k < 4; k++) begin
                if (wren && addr == 8'h18) mcnt[d][k] = int'(press[k]);
                else                       mcnt[d][k] = (mcnt[d][k] + int'(press[k])) % 256;
            end
            mdebp[d] = mdeb[d][21:18];
            mdeb[d]  = nd;
            rawh[d].push_back(cur);
            if (rawh[d].size() > 2) void'(rawh[d].pop_front());
        end
    endtask

    function automatic logic [31:0] mread(input int d, input logic [7:0] a);
        case (a)
            8'h00:   return {14'b0, mdeb[d][17:0]};
            8'h10:   return {28'b0, mdeb[d][21:18]};
            8'h14:   return {28'b0, mpress[d]};
            8'h18:   return {8'(mcnt[d][3]), 8'(mcnt[d][2]), 8'(mcnt[d][1]), 8'(mcnt[d][0])};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_a);
        model_step(1, rst_b);
        started = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (started) begin
            check("rdata_a", ba.rdata, mread(0, addr));
            check("irq_a", {31'b0, irq_a}, {31'b0, |mpress[0]});
            check("rdata_b", bb.rdata, mread(1, addr));
            check("irq_b", {31'b0, irq_b}, {31'b0, |mpress[1]});
        end
    end

    logic [7:0] offs [4] = '{8'h00, 8'h10, 8'h14, 8'h18};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        addr = 8'h00; sdata = 32'h0; wren = 1'b0; sw_raw = 32'h0; btn_raw = 32'h0;
        repeat (3) @(negedge clk);
        foreach (offs[i]) begin
            addr = offs[i];
            #1;
            check("reset_rd_a", ba.rdata, 32'h0);
            check("reset_rd_b", bb.rdata, 32'h0);
        end
        check("reset_irq_a", {31'b0, irq_a}, 32'h0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; addr = 8'h00;
        repeat (5) @(negedge clk);

        // switch latency: zero through edge N+3, value after N+4
        sw_raw = 32'h0000_02A5;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            check("sw_latency", ba.rdata, (k < 4) ? 32'h0 : 32'h0000_02A5);
        end
        sw_raw = 32'hFFFF_FFFF;
        repeat (6) @(negedge clk);
        check("sw_mask", ba.rdata, 32'h0003_FFFF);

        // 2-cycle glitch rejected
        btn_raw[0] = 1'b1;
        repeat (2) @(negedge clk);
        btn_raw[0] = 1'b0;
        repeat (10) @(negedge clk);
        addr = 8'h10; #1; check("glitch_btn", ba.rdata, 32'h0);
        addr = 8'h14; #1; check("glitch_press", ba.rdata, 32'h0);
        addr = 8'h18; #1; check("glitch_pcnt", ba.rdata, 32'h0);
        check("glitch_irq", {31'b0, irq_a}, 32'h0);

        // three presses of button 2, then write-1-to-clear
        repeat (3) begin
            btn_raw[2] = 1'b1;
            repeat (10) @(negedge clk);
            btn_raw[2] = 1'b0;
            repeat (10) @(negedge clk);
        end
        addr = 8'h14; #1; check("press3_flags", ba.rdata, 32'h0000_0004);
        addr = 8'h18; #1; check("press3_pcnt", ba.rdata, 32'h0003_0000);
        check("press3_irq", {31'b0, irq_a}, 32'h1);
        wren = 1'b1; addr = 8'h14; sdata = 32'h4;
        @(negedge clk);
        wren = 1'b0; sdata = 32'h0;
        #1;
        check("w1c_flags", ba.rdata, 32'h0);
        check("w1c_irq", {31'b0, irq_a}, 32'h0);

        // button 1 press edge coincides with a PRESS clear
        btn_raw[1] = 1'b1;
        repeat (5) @(negedge clk);
        wren = 1'b1; addr = 8'h14; sdata = 32'h2;
        @(negedge clk);
        wren = 1'b0; sdata = 32'h0;
        #1;
        check("coll_press", ba.rdata, 32'h0000_0002);
        check("coll_irq", {31'b0, irq_a}, 32'h1);
        btn_raw[1] = 1'b0;
        repeat (10) @(negedge clk);

        // button 1 press edge coincides with a PCNT clear
        btn_raw[1] = 1'b1;
        repeat (5) @(negedge clk);
        wren = 1'b1; addr = 8'h18; sdata = 32'hDEAD_BEEF;
        @(negedge clk);
        wren = 1'b0; sdata = 32'h0;
        #1;
        check("coll_pcnt", ba.rdata, 32'h0000_0100);
        btn_raw[1] = 1'b0;
        repeat (10) @(negedge clk);

        // 256 presses of button 0 wrap its counter with no carry
        repeat (256) begin
            btn_raw[0] = 1'b1;
            repeat (6) @(negedge clk);
            btn_raw[0] = 1'b0;
            repeat (6) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        addr = 8'h18; #1; check("wrap_pcnt", ba.rdata, 32'h0000_0100);
        addr = 8'h14; #1; check("wrap_press", ba.rdata, 32'h0000_0003);

        // reset the DB_DIV=4 instance mid-debounce
        sw_raw = 32'h0001_2345;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #2;
        foreach (offs[i]) begin
            addr = offs[i];
            #1;
            check("midrst_rd_b", bb.rdata, 32'h0);
        end
        check("midrst_irq_b", {31'b0, irq_b}, 32'h0);
        @(negedge clk);
        rst_b = 1'b0; addr = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #2;
            check("tick_restart", bb.rdata, (k < 12) ? 32'h0 : 32'h0001_2345);
        end
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
